// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying a control bundle and a data bundle between pipeline stages.
interface pipe_stage_skid_if #(
    parameter int W      = 16,
    parameter int CTRL_W = 19
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [W-1:0]      data;

    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked inter-stage register with 2-entry skid buffer and flush-to-bubble.
// Define PIPE_STAGE_PARITY_EN to store an even-parity bit per entry and flag corruption on err.
module pipe_stage_skid #(
    parameter int W      = 16,
    parameter int CTRL_W = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic                 err
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [W-1:0]      main_data, skid_data;
    logic              in_fire, out_fire;
    logic              ld_main_in, ld_main_skid, ld_skid;

    assign up.ready = (state != FULL);
    assign dn.valid = (state != EMPTY);
    assign dn.ctrl  = dn.valid ? main_ctrl : '0;
    assign dn.data  = main_data;

    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;

    // Load strobes shared by the entry registers and the optional parity bits.
    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (!flush) begin
            ld_main_in   = in_fire & ((state == EMPTY) | ((state == ONE) & out_fire));
            ld_skid      = in_fire & (state == ONE) & ~out_fire;
            ld_main_skid = (state == FULL) & out_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (ld_main_in) begin
                main_ctrl <= up.ctrl;
                main_data <= up.data;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (ld_skid) begin
                skid_ctrl <= up.ctrl;
                skid_data <= up.data;
            end
            // Flush only empties the stage; out_data keeps its last value.
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (in_fire) state <= ONE;
                    ONE: begin
                        if (in_fire && !out_fire)      state <= FULL;
                        else if (!in_fire && out_fire) state <= EMPTY;
                    end
                    FULL:    if (out_fire) state <= ONE;
                    default: state <= EMPTY;
                endcase
            end
        end
    end

`ifdef PIPE_STAGE_PARITY_EN
    logic main_par, skid_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_par <= 1'b0;
            skid_par <= 1'b0;
        end else begin
            if (ld_main_in)        main_par <= ^{up.ctrl, up.data};
            else if (ld_main_skid) main_par <= skid_par;
            if (ld_skid)           skid_par <= ^{up.ctrl, up.data};
        end
    end

    assign err = dn.valid & (main_par != ^{main_ctrl, main_data});
`else
    assign err = 1'b0;
`endif
endmodule
